// File: rtl/mult_share_arb.sv
// mult_share_arb: two-port arbiter/sequencer for one shared 4x4 Multiplierr.
// Round-robin by default; define MULT_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module Multiplierr #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

module mult_share_arb #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [2*W-1:0] p0,
  output logic [2*W-1:0] p1,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] ra, rb;
  logic [2*W-1:0] prod;
  logic win, pick1, grant;
  assign grant = state == IDLE && (req0 || req1);
`ifdef MULT_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic last;
  assign pick1 = req1 & (~req0 | ~last);
  always_ff @(posedge clk) begin
    if (rst) last <= 1'b1;
    else if (grant) last <= pick1;
  end
`endif
  Multiplierr #(.W(W)) u_mul (.a(ra), .b(rb), .p(prod));
  always_comb begin
    state_nx = state == IDLE ? (grant ? CALC : IDLE) : state == CALC ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      win   <= 1'b0;
      p0    <= '0;
      p1    <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ra  <= pick1 ? a1 : a0;
        rb  <= pick1 ? b1 : b0;
        win <= pick1;
      end
      if (state == CALC && !win) p0 <= prod;
      if (state == CALC && win) p1 <= prod;
    end
  end
  assign busy  = state != IDLE;
  assign gnt0  = busy & ~win;
  assign gnt1  = busy & win;
  assign done0 = state == DONE && !win;
  assign done1 = state == DONE && win;
endmodule
